dsp_overpack_mac: RTL and testbench

DSP_OVERPACK_MAC -- requirements
Module: dsp_overpack_mac

---
 rtl/overpack_pkg.sv | 28 ++
 rtl/overpack_extract.sv | 25 ++
 rtl/dsp_overpack_mac.sv | 124 ++++++++++++
 tb/tb_dsp_overpack_mac.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/overpack_pkg.sv
//==============================================================
// overpack_pkg -- shared defaults, lane indexing, saturation limits (rev 1.0)
//==============================================================
`default_nettype none
package overpack_pkg;

  localparam int DEF_A_W    = 4;
  localparam int DEF_W_W    = 4;
  localparam int DEF_N_ACT  = 3;
  localparam int DEF_N_WT   = 2;
  localparam int DEF_ACC_W  = 20;
  localparam int MAX_PROD_W = 48;

  // Lane k of weight i and activation j.
  function automatic int lane_idx(input int i, input int j, input int n_act);
    return i * n_act + j;
  endfunction

  function automatic logic signed [63:0] sat_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/overpack_extract.sv
//==============================================================
// overpack_extract -- splits a packed product into signed lanes (rev 1.0)
//==============================================================
`default_nettype none
module overpack_extract #(
  parameter int S = 8,
  parameter int L = 6
) (
  input  logic [L*S-1:0] prod,
  output logic [L*S-1:0] lanes
);

  for (genvar k = 0; k < L; k++) begin : g_lane
    if (k == 0) begin : g_first
      assign lanes[0 +: S] = prod[0 +: S];
    end else begin : g_rest
      // A negative sum in the lower lanes borrowed one from this field; add it back.
      logic [S-1:0] w_fix;
      assign w_fix = prod[k*S +: S] + {{(S-1){1'b0}}, prod[k*S-1]};
      assign lanes[k*S +: S] = w_fix;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dsp_overpack_mac.sv
//==============================================================
// dsp_overpack_mac -- N_WT x N_ACT products from one multiply, saturating MAC (rev 1.0)
//==============================================================
`default_nettype none
module dsp_overpack_mac
  import overpack_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int W_W   = DEF_W_W,
  parameter int N_ACT = DEF_N_ACT,
  parameter int N_WT  = DEF_N_WT,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_ACT*A_W-1:0]          in_act,
  input  logic [N_WT*W_W-1:0]           in_wt,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_WT*N_ACT*ACC_W-1:0]   out_acc,
  output logic [N_WT*N_ACT-1:0]         out_ovf
);

  localparam int c_lane_w = A_W + W_W;
  localparam int c_lanes  = N_WT * N_ACT;
  localparam int c_prod_w = c_lanes * c_lane_w;
  localparam int c_sum_w  = ACC_W + 1;
  localparam logic [ACC_W-1:0] c_acc_max = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] c_acc_min = ACC_W'(sat_min(ACC_W));

  if (c_prod_w > MAX_PROD_W || ACC_W < c_lane_w) begin : g_bad_params
    $error("dsp_overpack_mac: L*S=%0d (max %0d), ACC_W=%0d (min %0d)",
           c_prod_w, MAX_PROD_W, ACC_W, c_lane_w);
  end

  logic                          w_stall;
  logic signed [c_prod_w-1:0]    w_act_pack, w_wt_pack, w_wt_lane, w_prod;
  logic [c_prod_w-1:0]           w_lanes;
  logic [c_lanes-1:0][ACC_W-1:0] w_acc_next;
  logic [c_lanes-1:0]            w_sat;

  logic                          r_s1_vld, r_s1_last, r_s2_vld, r_s2_last;
  logic signed [c_prod_w-1:0]    r_s1_act, r_s1_wt, r_s2_prod;
  logic [c_lanes-1:0][ACC_W-1:0] r_acc;
  logic [c_lanes-1:0]            r_ovf;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  always_comb begin
    w_act_pack = '0;
    w_wt_pack  = '0;
    w_wt_lane  = '0;
    for (int j = 0; j < N_ACT; j++) begin
      w_act_pack[j*c_lane_w +: A_W] = in_act[j*A_W +: A_W];
    end
    for (int i = 0; i < N_WT; i++) begin
      w_wt_lane = c_prod_w'($signed(in_wt[i*W_W +: W_W]));
      w_wt_pack = w_wt_pack + (w_wt_lane <<< (lane_idx(i, 0, N_ACT) * c_lane_w));
    end
  end

  assign w_prod = r_s1_act * r_s1_wt;

  overpack_extract #(
    .S (c_lane_w),
    .L (c_lanes)
  ) u_extract (
    .prod  (r_s2_prod),
    .lanes (w_lanes)
  );

  // Overflow of the one-bit-wider sum is detected from its top two bits.
  for (genvar k = 0; k < c_lanes; k++) begin : g_acc
    logic signed [ACC_W:0] w_sum;
    assign w_sum = c_sum_w'($signed(r_acc[k]))
                 + c_sum_w'($signed(w_lanes[k*c_lane_w +: c_lane_w]));
    assign w_sat[k]      = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_acc_next[k] = !w_sat[k] ? w_sum[ACC_W-1:0]
                         : (w_sum[ACC_W] ? c_acc_min : c_acc_max);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_act  <= '0;
      r_s1_wt   <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_prod <= '0;
      r_acc     <= '0;
      r_ovf     <= '0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= '0;
    end else if (!w_stall) begin
      r_s1_vld  <= in_valid;
      r_s1_last <= in_last;
      r_s1_act  <= w_act_pack;
      r_s1_wt   <= w_wt_pack;
      r_s2_vld  <= r_s1_vld;
      r_s2_last <= r_s1_last;
      r_s2_prod <= w_prod;
      out_valid <= r_s2_vld & r_s2_last;
      if (r_s2_vld) begin
        if (r_s2_last) begin
          out_acc <= w_acc_next;
          out_ovf <= r_ovf | w_sat;
          r_acc   <= '0;
          r_ovf   <= '0;
        end else begin
          r_acc <= w_acc_next;
          r_ovf <= r_ovf | w_sat;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_overpack_mac.sv
//==============================================================
// tb_dsp_overpack_mac -- model-checked bench, ACC_W=20 and ACC_W=10 instances (rev 1.0)
//==============================================================
`default_nettype none
module tb_dsp_overpack_mac;
  import overpack_pkg::*;

  localparam int L = 6;

  logic CLK = 1'b0;
  logic RSTN, in_valid, in_last, out_ready;
  logic [11:0] in_act;
  logic [7:0]  in_wt;
  logic in_ready20, in_ready10, out_valid20, out_valid10;
  logic [119:0] out_acc20;
  logic [59:0]  out_acc10;
  logic [5:0]   ovf20, ovf10;

  always #5 CLK = ~CLK;

  dsp_overpack_mac dut20 (
    .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready20),
    .in_act(in_act), .in_wt(in_wt), .in_last(in_last), .out_valid(out_valid20),
    .out_ready(out_ready), .out_acc(out_acc20), .out_ovf(ovf20));

  dsp_overpack_mac #(.ACC_W(10)) dut10 (
    .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready10),
    .in_act(in_act), .in_wt(in_wt), .in_last(in_last), .out_valid(out_valid10),
    .out_ready(out_ready), .out_acc(out_acc10), .out_ovf(ovf10));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int acc20[L], acc10[L];
  bit [5:0] mov20, mov10;
  logic [119:0] q_acc20[$];
  logic [59:0]  q_acc10[$];
  logic [5:0]   q_ovf20[$], q_ovf10[$];

  function automatic int sat_add(input int a, input int p, input int accw, output bit hit);
    int s, mx, mn;
    s  = a + p;
    mx = (1 << (accw - 1)) - 1;
    mn = -(1 << (accw - 1));
    hit = 1'b0;
    if (s > mx) begin s = mx; hit = 1'b1; end
    if (s < mn) begin s = mn; hit = 1'b1; end
    return s;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < L; k++) begin acc20[k] = 0; acc10[k] = 0; end
    mov20 = '0;
    mov10 = '0;
  endtask

  task automatic model_beat(input logic [11:0] a, input logic [7:0] w, input logic last);
    int wv, av, p, k;
    bit h;
    logic [119:0] e20;
    logic [59:0]  e10;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 3; j++) begin
        wv = $signed(w[i*4 +: 4]);
        av = a[j*4 +: 4];
        p  = wv * av;
        k  = lane_idx(i, j, 3);
        acc20[k] = sat_add(acc20[k], p, 20, h); if (h) mov20[k] = 1'b1;
        acc10[k] = sat_add(acc10[k], p, 10, h); if (h) mov10[k] = 1'b1;
      end
    end
    if (last) begin
      for (int k2 = 0; k2 < L; k2++) begin
        e20[k2*20 +: 20] = 20'(acc20[k2]);
        e10[k2*10 +: 10] = 10'(acc10[k2]);
      end
      q_acc20.push_back(e20); q_ovf20.push_back(mov20);
      q_acc10.push_back(e10); q_ovf10.push_back(mov10);
      model_clear();
    end
  endtask

  // ---------------- per-cycle compare ----------------
  bit prev_stall20 = 0, prev_stall10 = 0;
  logic [126:0] snap20;
  logic [66:0]  snap10;

  always @(negedge CLK) begin
    if (!RSTN) begin
      model_clear();
      q_acc20.delete(); q_ovf20.delete(); q_acc10.delete(); q_ovf10.delete();
      prev_stall20 = 0; prev_stall10 = 0;
    end else begin
      check("in_ready20 rule", in_ready20, !(out_valid20 && !out_ready));
      check("in_ready10 rule", in_ready10, !(out_valid10 && !out_ready));
      if (prev_stall20) check("hold20", {out_valid20, ovf20, out_acc20}, snap20);
      if (prev_stall10) check("hold10", {out_valid10, ovf10, out_acc10}, snap10);
      if (out_valid20 && out_ready) begin
        if (q_acc20.size() == 0) check("unexpected out20", 1, 0);
        else begin
          check("acc20", out_acc20, q_acc20.pop_front());
          check("ovf20", ovf20, q_ovf20.pop_front());
        end
      end
      if (out_valid10 && out_ready) begin
        if (q_acc10.size() == 0) check("unexpected out10", 1, 0);
        else begin
          check("acc10", out_acc10, q_acc10.pop_front());
          check("ovf10", ovf10, q_ovf10.pop_front());
        end
      end
      prev_stall20 = out_valid20 && !out_ready;
      prev_stall10 = out_valid10 && !out_ready;
      snap20 = {out_valid20, ovf20, out_acc20};
      snap10 = {out_valid10, ovf10, out_acc10};
      if (in_valid && in_ready20) model_beat(in_act, in_wt, in_last);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [11:0] act3(input int a0, input int a1, input int a2);
    return {a2[3:0], a1[3:0], a0[3:0]};
  endfunction

  function automatic logic [7:0] wt2(input int w0, input int w1);
    return {w1[3:0], w0[3:0]};
  endfunction

  task automatic send(input logic [11:0] a, input logic [7:0] w, input logic last);
    int n = 0;
    in_valid = 1'b1; in_act = a; in_wt = w; in_last = last;
    forever begin
      @(negedge CLK);
      if (in_ready20) begin @(posedge CLK); #1; break; end
      @(posedge CLK); #1;
      n++;
      if (n > 100) begin check("send timeout", 1, 0); break; end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    forever begin
      @(negedge CLK);
      if (out_valid20) break;
      n++;
      if (n > 50) begin check("out_valid timeout", 1, 0); break; end
    end
  endtask

  task automatic lanes_eq(input string name, input bit sel10,
                          input int e0, input int e1, input int e2,
                          input int e3, input int e4, input int e5);
    int e[L];
    int v;
    e = '{e0, e1, e2, e3, e4, e5};
    for (int k = 0; k < L; k++) begin
      v = sel10 ? int'($signed(out_acc10[k*10 +: 10])) : int'($signed(out_acc20[k*20 +: 20]));
      check(name, v, e[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTN = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_act = '0; in_wt = '0; out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset out_valid", {out_valid20, out_valid10}, 2'b00);
    check("reset out_acc20", out_acc20, 0);
    check("reset out_ovf",   {ovf20, ovf10}, 0);
    @(posedge CLK); #1 RSTN = 1'b1;
    @(negedge CLK);
    check("in_ready after reset", {in_ready20, in_ready10}, 2'b11);
    @(posedge CLK); #1;

    // single beat, latency 3
    send(act3(1, 2, 3), wt2(-1, 2), 1'b1);
    @(negedge CLK); check("latency edge1", {out_valid20, out_valid10}, 2'b00);
    @(negedge CLK); check("latency edge2", {out_valid20, out_valid10}, 2'b00);
    @(negedge CLK); check("latency edge3", {out_valid20, out_valid10}, 2'b11);
    lanes_eq("single20", 1'b0, -1, -2, -3, 2, 4, 6);
    lanes_eq("single10", 1'b1, -1, -2, -3, 2, 4, 6);
    @(posedge CLK); #1;

    // extremes with borrow correction
    for (int b = 0; b < 4; b++) send(act3(15, 15, 15), wt2(-8, -8), b == 3);
    wait_out();
    lanes_eq("extreme20", 1'b0, -480, -480, -480, -480, -480, -480);
    lanes_eq("extreme10", 1'b1, -480, -480, -480, -480, -480, -480);
    check("extreme ovf", {ovf20, ovf10}, 0);
    @(posedge CLK); #1;

    // saturation on the narrow accumulator, then a clean vector
    for (int b = 0; b < 5; b++) send(act3(15, 15, 15), wt2(7, 7), b == 4);
    wait_out();
    lanes_eq("sat10", 1'b1, 511, 511, 511, 511, 511, 511);
    lanes_eq("nosat20", 1'b0, 525, 525, 525, 525, 525, 525);
    check("sat ovf10", ovf10, 6'h3f);
    check("sat ovf20", ovf20, 6'h00);
    @(posedge CLK); #1;
    send(act3(1, 1, 1), wt2(1, 1), 1'b1);
    wait_out();
    check("ovf cleared", ovf10, 6'h00);
    lanes_eq("after sat10", 1'b1, 1, 1, 1, 1, 1, 1);
    @(posedge CLK); #1;

    // back-pressure with back-to-back vectors
    out_ready = 1'b0;
    fork
      begin
        send(act3(2, 3, 4), wt2(1, -1), 1'b1);
        send(act3(1, 1, 1), wt2(3, 3), 1'b0);
        send(act3(2, 2, 2), wt2(-2, -2), 1'b1);
        send(act3(7, 0, 5), wt2(-3, 4), 1'b1);
      end
      begin
        wait_out();
        lanes_eq("stall first", 1'b0, 2, 3, 4, -2, -3, -4);
        check("in_ready low in stall", {in_ready20, in_ready10}, 2'b00);
        repeat (5) @(posedge CLK);
        #1 out_ready = 1'b1;
      end
    join
    repeat (12) @(posedge CLK);
    check("stall drained", q_acc20.size() + q_acc10.size(), 0);
    #1;

    // reset in mid-vector
    send(act3(5, 5, 5), wt2(3, 3), 1'b0);
    send(act3(5, 5, 5), wt2(3, 3), 1'b0);
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;
    send(act3(1, 2, 3), wt2(1, 1), 1'b0);
    send(act3(1, 1, 1), wt2(2, -3), 1'b1);
    wait_out();
    lanes_eq("post reset20", 1'b0, 3, 4, 5, -2, -1, 0);
    lanes_eq("post reset10", 1'b1, 3, 4, 5, -2, -1, 0);

    repeat (10) @(posedge CLK);
    check("final drain", q_acc20.size() + q_acc10.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
